// File: rtl/fmac_result_packer.sv
// FMAC output stage: normalize, round and pack an unpacked result into IEEE-754 binary32.
// Optional macro FMAC_FTZ_EN flushes subnormal results to signed zero instead of gradual underflow.
module fmac_result_packer #(
    parameter int MANT_W = 50,
    parameter int EXP_W  = 10,
    parameter int LZC_W  = 7
) (
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    input  logic              Flush_SI,
    input  logic              In_Valid_SI,
    output logic              In_Ready_SO,
    input  logic              Sign_DI,
    input  logic [EXP_W-1:0]  Exp_DI,
    input  logic [MANT_W-1:0] Mant_DI,
    input  logic              Sticky_DI,
    input  logic [1:0]        RM_DI,
    input  logic              NaN_DI,
    input  logic              Inf_DI,
    input  logic              Zero_DI,
    output logic              Out_Valid_SO,
    input  logic              Out_Ready_SI,
    output logic [31:0]       Result_DO,
    output logic              OF_SO,
    output logic              UF_SO,
    output logic              NX_SO
);
    localparam int EW     = EXP_W + 2;
    localparam int SH_MAX = MANT_W + 2;
    localparam int SH_W   = $clog2(SH_MAX + 1);
    localparam int WIDE_W = 2 * MANT_W + 2;
    localparam int G_POS  = MANT_W - 25;

    typedef logic signed [EW-1:0] exp_t;

    typedef struct packed {
        logic              sign;
        logic [1:0]        rm;
        logic              nan;
        logic              inf;
        logic              zero;
        logic              cancel;
        logic              tiny;
        logic              sticky;
        exp_t              exp;
        logic [MANT_W-1:0] mant;
    } s1_t;

    typedef struct packed {
        logic [31:0] res;
        logic        of;
        logic        uf;
        logic        nx;
    } s2_t;

    function automatic logic [LZC_W-1:0] lzc(input logic [MANT_W-1:0] m);
        logic [LZC_W-1:0] cnt;
        logic             found;
        cnt   = LZC_W'(MANT_W);
        found = 1'b0;
        for (int i = MANT_W - 1; i >= 0; i--) begin
            if (m[i] && !found) begin
                cnt   = LZC_W'(MANT_W - 1 - i);
                found = 1'b1;
            end
        end
        return cnt;
    endfunction

    function automatic logic round_up(input logic [1:0] rm, input logic sign,
                                      input logic g, input logic s, input logic lsb);
        logic up;
        case (rm)
            2'd0:    up = g & (s | lsb);
            2'd1:    up = 1'b0;
            2'd2:    up = (g | s) & ~sign;
            default: up = (g | s) & sign;
        endcase
        return up;
    endfunction

    // Directed-away modes saturate to max finite; directed-toward modes go to infinity.
    function automatic logic [31:0] overflow_word(input logic [1:0] rm, input logic sign);
        logic to_inf;
        case (rm)
            2'd0:    to_inf = 1'b1;
            2'd1:    to_inf = 1'b0;
            2'd2:    to_inf = ~sign;
            default: to_inf = sign;
        endcase
        return {sign, to_inf ? 31'h7F80_0000 : 31'h7F7F_FFFF};
    endfunction

    logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic s1_adv, s2_adv, s1_load, s2_load;
    s1_t  s1_q, s1_d, s1_new;
    s2_t  s2_q, s2_d, s2_new;

    always_comb begin
        s2_adv      = ~s2_valid_q | Out_Ready_SI;
        s1_adv      = ~s1_valid_q | s2_adv;
        In_Ready_SO = s1_adv;
        s1_load     = In_Valid_SI & s1_adv;
        s2_load     = s1_valid_q & s2_adv;
        s1_valid_d  = s1_adv ? In_Valid_SI : s1_valid_q;
        s2_valid_d  = s2_adv ? s1_valid_q : s2_valid_q;
        if (Flush_SI) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // Stage 1: leading-one detect, normalize, denormal right shift into sticky.
    logic [LZC_W-1:0]  lz;
    exp_t              e_raw, sh;
    logic [SH_W-1:0]   amt;
    logic [MANT_W-1:0] m_shl;
    logic [WIDE_W-1:0] wide;

    always_comb begin
        lz    = lzc(Mant_DI);
        e_raw = exp_t'($signed(Exp_DI)) + exp_t'(1) - exp_t'(lz);
        m_shl = Mant_DI << lz;
        sh    = exp_t'(1) - e_raw;
        amt   = '0;
        if (e_raw < exp_t'(1))
            amt = (sh > exp_t'(SH_MAX)) ? SH_W'(SH_MAX) : sh[SH_W-1:0];
        wide  = {m_shl, {(MANT_W + 2){1'b0}}} >> amt;

        s1_new.sign   = Sign_DI;
        s1_new.rm     = RM_DI;
        s1_new.nan    = NaN_DI;
        s1_new.inf    = Inf_DI;
        s1_new.zero   = Zero_DI;
        s1_new.cancel = (Mant_DI == '0) & ~Sticky_DI;
        if (e_raw >= exp_t'(1)) begin
            s1_new.tiny   = 1'b0;
            s1_new.exp    = e_raw;
            s1_new.mant   = m_shl;
            s1_new.sticky = Sticky_DI;
        end else begin
            s1_new.tiny   = 1'b1;
            s1_new.exp    = '0;
            s1_new.mant   = wide[WIDE_W-1 -: MANT_W];
            s1_new.sticky = Sticky_DI | (|wide[MANT_W+1:0]);
        end
        s1_d = s1_load ? s1_new : s1_q;
    end

    // Stage 2: round, overflow handling, pack, flags and special-case override.
    exp_t        e1, exp_out;
    logic [23:0] mant24;
    logic [24:0] sum;
    logic        g_bit, s_bit, ovf;

    always_comb begin
        e1      = s1_q.exp;
        mant24  = s1_q.mant[MANT_W-1 -: 24];
        g_bit   = s1_q.mant[G_POS];
        s_bit   = (|s1_q.mant[G_POS-1:0]) | s1_q.sticky;
        sum     = {1'b0, mant24} + 25'(round_up(s1_q.rm, s1_q.sign, g_bit, s_bit, mant24[0]));
        exp_out = (e1 == '0) ? exp_t'(sum[23]) : e1 + exp_t'(sum[24]);
        ovf     = exp_out >= exp_t'(255);

        s2_new.of  = ovf;
        s2_new.nx  = g_bit | s_bit | ovf;
        s2_new.uf  = s1_q.tiny & (g_bit | s_bit | ovf);
        s2_new.res = ovf ? overflow_word(s1_q.rm, s1_q.sign)
                         : {s1_q.sign, exp_out[7:0], sum[22:0]};
`ifdef FMAC_FTZ_EN
        if (!ovf && exp_out == '0 && sum[22:0] != '0) begin
            s2_new.res = {s1_q.sign, 31'h0};
            s2_new.uf  = 1'b1;
            s2_new.nx  = 1'b1;
        end
`endif
        if (s1_q.nan) begin
            s2_new = '{res: 32'h7FC0_0000, of: 1'b0, uf: 1'b0, nx: 1'b0};
        end else if (s1_q.inf) begin
            s2_new = '{res: {s1_q.sign, 31'h7F80_0000}, of: 1'b0, uf: 1'b0, nx: 1'b0};
        end else if (s1_q.zero) begin
            s2_new = '{res: {s1_q.sign, 31'h0}, of: 1'b0, uf: 1'b0, nx: 1'b0};
        end else if (s1_q.cancel) begin
            s2_new = '{res: {s1_q.rm == 2'd3, 31'h0}, of: 1'b0, uf: 1'b0, nx: 1'b0};
        end
        s2_d = s2_load ? s2_new : s2_q;
    end

    always_ff @(posedge Clk_CI) begin
        s1_q <= s1_d;
        s2_q <= s2_d;
    end

    // Data registers carry no reset; gating by valid gives zeros out of reset.
    always_comb begin
        Out_Valid_SO = s2_valid_q;
        Result_DO    = s2_valid_q ? s2_q.res : 32'h0;
        OF_SO        = s2_valid_q & s2_q.of;
        UF_SO        = s2_valid_q & s2_q.uf;
        NX_SO        = s2_valid_q & s2_q.nx;
    end

endmodule

// File: tb/tb_fmac_result_packer.sv
// Scoreboard bench for fmac_result_packer: directed corner cases, stall/flush/reset and random traffic.
module tb_fmac_result_packer;
    logic        clk = 1'b0;
    logic        Rst_RBI, Flush_SI, In_Valid_SI, In_Ready_SO;
    logic        Sign_DI, Sticky_DI, NaN_DI, Inf_DI, Zero_DI;
    logic [9:0]  Exp_DI;
    logic [49:0] Mant_DI;
    logic [1:0]  RM_DI;
    logic        Out_Valid_SO, Out_Ready_SI, OF_SO, UF_SO, NX_SO;
    logic [31:0] Result_DO;

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;
    logic [34:0] exp_q[$];

    fmac_result_packer dut (
        .Clk_CI(clk), .Rst_RBI(Rst_RBI), .Flush_SI(Flush_SI),
        .In_Valid_SI(In_Valid_SI), .In_Ready_SO(In_Ready_SO),
        .Sign_DI(Sign_DI), .Exp_DI(Exp_DI), .Mant_DI(Mant_DI), .Sticky_DI(Sticky_DI),
        .RM_DI(RM_DI), .NaN_DI(NaN_DI), .Inf_DI(Inf_DI), .Zero_DI(Zero_DI),
        .Out_Valid_SO(Out_Valid_SO), .Out_Ready_SI(Out_Ready_SI),
        .Result_DO(Result_DO), .OF_SO(OF_SO), .UF_SO(UF_SO), .NX_SO(NX_SO)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Value = M * 2^(Exp-175); result is round(value / quantum) where the quantum is
    // 2^(ue-23) for normal numbers and 2^-149 below the normal range.
    function automatic logic [34:0] model(input logic sg, input logic [9:0] ex, input logic [49:0] mt,
                                          input logic stk, input logic [1:0] rm,
                                          input logic nan, input logic inf, input logic zero);
        longint m, n, bits;
        int x, p, ue, qe, k;
        logic g, s, up, of, nx, uf, tiny, to_inf;
        logic [31:0] res;
        if (nan)  return {32'h7FC00000, 3'b000};
        if (inf)  return {sg, 31'h7F800000, 3'b000};
        if (zero) return {sg, 31'h0, 3'b000};
        if (mt == 0 && !stk) return {(rm == 2'd3), 31'h0, 3'b000};
        m = longint'(mt);
        x = int'($signed(ex)) - 127 - 48;
        p = 0;
        for (int i = 0; i < 50; i++) if (mt[i]) p = i;
        ue   = p + x;
        tiny = (ue < -126);
        qe   = (tiny ? -126 : ue) - 23;
        k    = qe - x;
        if (k <= 0) begin
            n = m << (-k); g = 1'b0; s = stk;
        end else if (k > 60) begin
            n = 0; g = 1'b0; s = (m != 0) | stk;
        end else begin
            n = m >> k;
            g = m[k-1];
            s = ((m & ((64'sd1 << (k - 1)) - 1)) != 0) | stk;
        end
        case (rm)
            2'd0: up = g & (s | n[0]);
            2'd1: up = 1'b0;
            2'd2: up = (g | s) & !sg;
            default: up = (g | s) & sg;
        endcase
        n = n + longint'(up);
        if (tiny) bits = n;
        else      bits = (longint'(ue + 127) << 23) + n - 64'sd8388608;
        of  = (bits >= longint'(32'h7F800000));
        nx  = g | s | of;
        uf  = tiny & nx;
        res = {sg, bits[30:0]};
        if (of) begin
            to_inf = (rm == 2'd0) || (rm == 2'd2 && !sg) || (rm == 2'd3 && sg);
            res = to_inf ? {sg, 31'h7F800000} : {sg, 31'h7F7FFFFF};
        end
`ifdef FMAC_FTZ_EN
        if (!of && bits != 0 && bits < 64'sd8388608) begin
            res = {sg, 31'h0}; uf = 1'b1; nx = 1'b1;
        end
`endif
        return {res, of, uf, nx};
    endfunction

    task automatic set_data(input logic sg, input logic [9:0] ex, input logic [49:0] mt, input logic stk,
                            input logic [1:0] rm, input logic nan, input logic inf, input logic zero);
        Sign_DI = sg; Exp_DI = ex; Mant_DI = mt; Sticky_DI = stk;
        RM_DI = rm; NaN_DI = nan; Inf_DI = inf; Zero_DI = zero;
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input logic v, input logic fl, input logic ordy,
                        input logic use_c, input logic [34:0] cexp, output logic acc);
        logic rdy;
        In_Valid_SI = v; Flush_SI = fl; Out_Ready_SI = ordy;
        @(negedge clk);
        rdy = In_Ready_SO;
        #1;
        acc = v && rdy && !fl;
        if (acc)
            exp_q.push_back(use_c ? cexp : model(Sign_DI, Exp_DI, Mant_DI, Sticky_DI,
                                                 RM_DI, NaN_DI, Inf_DI, Zero_DI));
        if (fl) exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic send_c(input string name, input logic [34:0] cexp);
        logic acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            step(1'b1, 1'b0, 1'b1, 1'b1, cexp, acc);
            tries++;
        end
        if (!acc) begin
            n_checks++; n_errors++;
            $display("FAIL %s_accept: input not accepted within 20 cycles", name);
        end
        In_Valid_SI = 1'b0;
    endtask

    task automatic drain();
        logic acc;
        int tries;
        tries = 0;
        while (exp_q.size() != 0 && tries < 30) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, '0, acc);
            tries++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks hold stability.
    initial begin
        logic [34:0] e, held;
        logic prev_hold;
        prev_hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!Rst_RBI) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold)
                    check("hold_stable", {Out_Valid_SO, Result_DO, OF_SO, UF_SO, NX_SO}, {1'b1, held});
                if (Out_Valid_SO && Out_Ready_SI) begin
                    if (exp_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_output: got %h, expected no output", Result_DO);
                    end else begin
                        e = exp_q.pop_front();
                        n_pops++;
                        check("result", {Result_DO, OF_SO, UF_SO, NX_SO}, e);
                    end
                end
                prev_hold = Out_Valid_SO && !Out_Ready_SI && !Flush_SI;
                held = {Result_DO, OF_SO, UF_SO, NX_SO};
            end
        end
    end

    initial begin
        logic acc;
        logic [63:0] r;
        int ev, pops0;
        Rst_RBI = 1'b0; Flush_SI = 1'b0; In_Valid_SI = 1'b0; Out_Ready_SI = 1'b1;
        set_data(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", Out_Valid_SO, 0);
        check("rst_result", {Result_DO, OF_SO, UF_SO, NX_SO}, 0);
        Rst_RBI = 1'b1;
        #1;
        check("rst_in_ready", In_Ready_SO, 1);
        @(posedge clk);
        #1;

        // Latency: 1.0 appears exactly two edges after acceptance.
        set_data(0, 10'd127, 50'h1 << 48, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b1, 1'b1, {32'h3F800000, 3'b000}, acc);
        check("lat_accept", acc, 1);
        check("lat_not_yet", Out_Valid_SO, 0);
        In_Valid_SI = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, acc);
        check("lat_valid", Out_Valid_SO, 1);
        check("lat_result", Result_DO, 32'h3F800000);
        drain();

        // Directed rounding, overflow, denormal and special cases.
        set_data(0, 10'd127, (50'h1 << 48) | (50'h1 << 24), 0, 0, 0, 0, 0);
        send_c("tie_even", {32'h3F800000, 3'b001});
        set_data(0, 10'd127, (50'h1 << 48) | (50'h1 << 25) | (50'h1 << 24), 0, 0, 0, 0, 0);
        send_c("tie_odd", {32'h3F800002, 3'b001});
        set_data(0, 10'd254, 50'h3 << 48, 0, 0, 0, 0, 0);
        send_c("ovf_rne", {32'h7F800000, 3'b101});
        set_data(0, 10'd254, 50'h3 << 48, 0, 1, 0, 0, 0);
        send_c("ovf_rtz", {32'h7F7FFFFF, 3'b101});
        set_data(1, 10'd254, 50'h3 << 48, 0, 3, 0, 0, 0);
        send_c("ovf_rdn_neg", {32'hFF800000, 3'b101});
        set_data(0, 10'd254, 50'h3 << 48, 0, 3, 0, 0, 0);
        send_c("ovf_rdn_pos", {32'h7F7FFFFF, 3'b101});
        set_data(0, -10'sd22, 50'h1 << 48, 0, 0, 0, 0, 0);
`ifdef FMAC_FTZ_EN
        send_c("min_denorm", {32'h00000000, 3'b011});
`else
        send_c("min_denorm", {32'h00000001, 3'b000});
`endif
        set_data(0, 10'd0, 50'h0, 0, 0, 1, 1, 0);
        send_c("nan_over_inf", {32'h7FC00000, 3'b000});
        set_data(1, 10'd0, 50'h0, 0, 0, 0, 1, 0);
        send_c("neg_inf", {32'hFF800000, 3'b000});
        set_data(0, 10'd0, 50'h0, 0, 3, 0, 0, 0);
        send_c("cancel_rdn", {32'h80000000, 3'b000});
        set_data(1, 10'd0, 50'h0, 0, 0, 0, 0, 0);
        send_c("cancel_rne", {32'h00000000, 3'b000});
        drain();

        // Backpressure: three inputs, output stalled for five cycles, then released.
        set_data(0, 10'd127, 50'h1 << 48, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, acc);
        set_data(1, 10'd128, 50'h1 << 48, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, acc);
        check("stall_in_ready", In_Ready_SO, 0);
        set_data(0, 10'd130, 50'h3 << 47, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, acc);
        check("stall_third_blocked", acc, 0);
        check("stall_out_valid", Out_Valid_SO, 1);
        check("stall_held_result", Result_DO, 32'h3F800000);
        pops0 = n_pops;
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, acc);
        check("release_accept", acc, 1);
        In_Valid_SI = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, acc);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, acc);
        check("release_three_in_three", n_pops - pops0, 3);
        drain();

        // Flush mid-stall drops everything in flight.
        set_data(0, 10'd100, 50'h1 << 49, 1, 2, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, acc);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, acc);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, acc);
        pops0 = n_pops;
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, acc);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0, acc);
        check("flush_no_output", n_pops - pops0, 0);
        check("flush_valid_low", Out_Valid_SO, 0);

        // Asynchronous reset mid-stream.
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, acc);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, acc);
        In_Valid_SI = 1'b0;
        #2;
        Rst_RBI = 1'b0;
        #1;
        check("async_rst_valid", Out_Valid_SO, 0);
        check("async_rst_result", Result_DO, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        Rst_RBI = 1'b1;
        pops0 = n_pops;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0, acc);
        check("rst_no_stale", n_pops - pops0, 0);

        // Random traffic against the reference model.
        for (int i = 0; i < 2500; i++) begin
            r = {$urandom(), $urandom()};
            ev = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) - 512
                                              : int'($urandom_range(0, 360)) - 60;
            set_data(1'($urandom_range(0, 1)), 10'(ev), r[49:0] >> $urandom_range(0, 49),
                     1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                     $urandom_range(0, 15) == 0);
            if (Mant_DI == 0) Mant_DI = 50'h1;
            if ($urandom_range(0, 31) == 0) begin Mant_DI = '0; Sticky_DI = 1'b0; end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) != 0, 1'b0, '0, acc);
        end
        Flush_SI = 1'b0;
        In_Valid_SI = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fmac_result_packer.md
Name: fmac_result_packer

Overview:
Output end of the single-precision FMAC datapath. It accepts an unpacked, un-normalized result: sign, wide biased exponent, wide mantissa, sticky bit and special-case flags. It normalizes, rounds by the 2-bit rounding mode and packs an IEEE-754 binary32 word with exception flags. Two-stage valid/ready pipeline between the FMAC adder and the FPU writeback.

Parameters:
MANT_W, 50, input mantissa width; top 2 bits are integer bits, value = Mant_DI / 2^(MANT_W-2) * 2^(Exp_DI-127)
EXP_W, 10, input exponent width, two's complement, biased by 127
LZC_W, 7, leading-zero count width; must satisfy 2^LZC_W >= MANT_W

Ports:
Clk_CI  in  1  clock
Rst_RBI  in  1  asynchronous active-low reset
Flush_SI  in  1  synchronous clear of all pipeline valids
In_Valid_SI  in  1  input beat valid
In_Ready_SO  out  1  input beat accepted when In_Valid_SI & In_Ready_SO
Sign_DI  in  1  result sign
Exp_DI  in  EXP_W  signed biased exponent
Mant_DI  in  MANT_W  un-normalized magnitude
Sticky_DI  in  1  OR of mantissa bits already discarded upstream
RM_DI  in  2  0 nearest-even, 1 trunc, 2 +inf, 3 -inf
NaN_DI  in  1  result is NaN
Inf_DI  in  1  result is infinity
Zero_DI  in  1  result is exact zero
Out_Valid_SO  out  1  result valid
Out_Ready_SI  in  1  downstream accepts
Result_DO  out  32  packed binary32
OF_SO / UF_SO / NX_SO  out  1 each  overflow, underflow, inexact

Behaviour:
- Reset: both stage valids 0. Out_Valid_SO=0, Result_DO=0, OF/UF/NX=0. In_Ready_SO=1 combinationally after reset.
- Pipeline: S1 is leading-one detect, shift and exponent adjust. S2 is round, overflow handling, pack and flags. Latency is exactly 2 cycles with no backpressure.
- S2 advances when ~s2_valid | Out_Ready_SI. S1 advances when ~s1_valid | S2 advances. In_Ready_SO = S1 advances, a combinational path from Out_Ready_SI.
- Outputs are held stable while Out_Valid_SO & ~Out_Ready_SI. Full throughput is 1 result per cycle. Results leave in order and are never dropped or duplicated.
- Flush_SI clears both valids next edge and has priority over capture. An input presented in the flush cycle is discarded.
- Normalize (S1):
  - L = leading zeros of Mant_DI.
  - E = Exp_DI + 1 - L.
  - If E >= 1: shift left by L, exponent field = E.
  - If E <= 0: denormal. Shift left by L, then right by 1-E (saturate at MANT_W+2). Shifted-out bits are ORed into sticky. Exponent field = 0.
- Mantissa/round bits (S2): keep 24 bits (hidden + 23). G is the next bit. S = OR of the remaining bits | Sticky_DI.
- Increment rule by mode:
  - Nearest: G & (S | LSB).
  - Trunc: never.
  - +inf: (G|S) & ~sign.
  - -inf: (G|S) & sign.
- A mantissa carry-out sets exponent +1. A denormal that rounds up into the hidden bit becomes exponent 1.
- Overflow: exponent field >= 255 after rounding sets OF=1 and NX=1. Result by mode:
  - Nearest: ±inf.
  - Trunc: ±0x7F7FFFFF.
  - +inf: +inf / -max.
  - -inf: +max / -inf.
- Flags: NX = G|S|OF. UF = tiny before rounding (E <= 0) & NX.
- Specials, priority NaN > Inf > Zero > numeric:
  - NaN: 0x7FC00000, flags 0.
  - Inf: sign, 0xFF, 0.
  - Zero: sign, all 0.
- Mant_DI == 0 with Zero_DI=0 and Sticky_DI=0 is exact cancellation: +0, or -0 when RM=3, flags 0.
- Exp_DI and all data inputs are sampled only on handshake.

Optional Feature:
FMAC_FTZ_EN.
- Defined: any result that would pack with exponent field 0 and nonzero mantissa is flushed to signed zero, with UF=1 and NX=1.
- Undefined: gradual underflow as above.

Test Plan:
- Exp_DI=127, Mant_DI=01 followed by zeros, RM=0 -> Result_DO=0x3F800000, flags 0, Out_Valid_SO exactly 2 cycles after accept.
- Value 1 + 2^-24 exactly (G=1, S=0, LSB=0), RM=0 -> 0x3F800000, NX=1. Same with LSB=1 (1+2^-23+2^-24) -> 0x3F800002, NX=1.
- Exp_DI=254, Mant_DI integer bits 11 -> RM=0: 0x7F800000, OF=1, NX=1. RM=1: 0x7F7FFFFF, OF=1, NX=1. RM=3 with sign=1: 0xFF800000.
- Exp_DI=-22, Mant_DI=01 followed by zeros (2^-149) -> 0x00000001, UF=0, NX=0. With FMAC_FTZ_EN -> 0x00000000, UF=1, NX=1.
- Three back-to-back inputs with Out_Ready_SI=0 for 5 cycles:
  - Two results are held and In_Ready_SO=0 after the second.
  - On release, all three emerge in order, one per cycle.
  - Flush_SI mid-stall -> no outputs.
- NaN_DI=1 with Inf_DI=1 -> 0x7FC00000. Rst_RBI asserted mid-stream -> Out_Valid_SO=0 immediately (asynchronously), no stale result after release.
